// File: rtl/led_mode_unit.sv
// led_mode_unit: drives WIDTH LEDs from WIDTH switches in one of four modes
// (PASS, INVERT, ROTATE, BLINK). Each debounced press of the active-low key
// steps to the next mode.
module led_mode_unit #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TICK_DIV        = 12500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] ledr,
    output logic [1:0]       mode
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned TK_W = $clog2(TICK_DIV);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        M_PASS   = 2'd0,
        M_INVERT = 2'd1,
        M_ROTATE = 2'd2,
        M_BLINK  = 2'd3
    } mode_t;

    logic             key_s1;
    logic             key_s2;
    logic             key_db;
    logic [DB_W-1:0]  db_cnt;
    logic             press_c;
    logic             tick_c;
    mode_t            mode_q;
    mode_t            mode_nxt_c;
    logic [TK_W-1:0]  tick_cnt;
    logic [WIDTH-1:0] pattern;
    logic             phase;

    // Two-flop synchronizer for the asynchronous key pin; idles released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
        end else begin
            key_s1 <= key;
            key_s2 <= key_s1;
        end
    end

    // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive differing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_db <= 1'b1;
            db_cnt <= '0;
        end else if (key_s2 == key_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            key_db <= key_s2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // A press is the debounced 1->0 flip; release has no effect.
    assign press_c    = key_db & ~key_s2 & (db_cnt == DB_LAST);
    assign tick_c     = (tick_cnt == TK_LAST);
    assign mode_nxt_c = mode_t'(mode_q + 2'd1);

    // Mode machine with tick counter, rotate pattern and blink phase; mode entry beats tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= M_PASS;
            tick_cnt <= '0;
            pattern  <= '0;
            phase    <= 1'b1;
        end else if (press_c) begin
            mode_q   <= mode_nxt_c;
            tick_cnt <= '0;
            if (mode_nxt_c == M_ROTATE) begin
                pattern <= sw;
            end
            if (mode_nxt_c == M_BLINK) begin
                phase <= 1'b1;
            end
        end else begin
            tick_cnt <= tick_c ? '0 : tick_cnt + TK_W'(1);
            if (tick_c && (mode_q == M_ROTATE)) begin
                pattern <= {pattern[WIDTH-2:0], pattern[WIDTH-1]};
            end
            if (tick_c && (mode_q == M_BLINK)) begin
                phase <= ~phase;
            end
        end
    end

    // LED drive, one edge behind the mode and its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ledr <= '0;
        end else begin
            case (mode_q)
                M_PASS:   ledr <= sw;
                M_INVERT: ledr <= ~sw;
                M_ROTATE: ledr <= pattern;
                M_BLINK:  ledr <= phase ? sw : '0;
                default:  ledr <= sw;
            endcase
        end
    end

    assign mode = mode_q;

endmodule
